// File: rtl/zipdma_checkn.sv
`default_nettype none
// ============================================================================
//  Module      : zipdma_checkn
//  Description : Multi-channel Wishbone LFSR data source/sink for DMA testing.
//                Per channel: seeded read stream, write checker, byte counts,
//                saturating mismatch count, sticky error flag, first bad
//                address and programmable stall injection. A 32-bit status
//                port gives access to per-channel SEED/COUNTS/ERRCTL/FIRST.
//  Revision    : 1.0 - initial release
// ============================================================================
module zipdma_checkn #(
    parameter int  ADDRESS_WIDTH = 30,
    parameter int  BUS_WIDTH     = 64,
    parameter int  NCHAN         = 4,
    localparam int DW            = BUS_WIDTH,
    localparam int SW            = BUS_WIDTH / 8,
    localparam int AW            = ADDRESS_WIDTH - $clog2(BUS_WIDTH / 8),
    localparam int CW            = $clog2(NCHAN),
    localparam int SAW           = CW + 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [SW-1:0]   i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_wb_err,
    input  logic            i_st_cyc,
    input  logic            i_st_stb,
    input  logic            i_st_we,
    input  logic [SAW-1:0]  i_st_addr,
    input  logic [31:0]     i_st_data,
    input  logic [3:0]      i_st_sel,
    output logic            o_st_stall,
    output logic            o_st_ack,
    output logic [31:0]     o_st_data,
    output logic            o_st_err
);
    localparam int CIW = (CW > 0) ? CW : 1;

    // Per-channel state
    logic [31:0]    seed_q      [NCHAN];
    logic [DW-1:0]  rd_lfsr_q   [NCHAN];
    logic [DW-1:0]  wr_lfsr_q   [NCHAN];
    logic [15:0]    rd_bytes_q  [NCHAN];
    logic [15:0]    wr_bytes_q  [NCHAN];
    logic [15:0]    err_cnt_q   [NCHAN];
    logic           err_flag_q  [NCHAN];
    logic [AW-1:0]  first_addr_q[NCHAN];
    logic [3:0]     stall_p_q   [NCHAN];
    logic [3:0]     stall_cnt_q [NCHAN];

    // Bus output registers
    logic           wb_ack_q;
    logic [DW-1:0]  wb_data_q;
    logic           st_ack_q;
    logic [31:0]    st_data_q;

    logic [CIW-1:0] w_wb_ch;
    logic [CIW-1:0] w_st_ch;
    logic           w_wb_req;
    logic           w_stall;
    logic           w_accept;
    logic           w_live;
    logic           w_st_req;
    logic           w_seed_wr;
    logic           w_ctl_wr;
    logic [31:0]    w_new_seed;
    logic [DW-1:0]  w_seed_init;
    logic [DW-1:0]  w_bmask;
    logic           w_mismatch;
    logic [15:0]    w_nbytes;
    logic [31:0]    w_st_rdata;

    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        return {s[DW-2:0], s[DW-1] ^ s[DW-2]};
    endfunction

    // Channel selection; a single-channel build has no channel bits
    generate
        if (CW > 0) begin : g_multi_chan
            assign w_wb_ch = i_wb_addr[AW-1 -: CW];
            assign w_st_ch = i_st_addr[SAW-1 -: CW];
        end else begin : g_single_chan
            assign w_wb_ch = '0;
            assign w_st_ch = '0;
        end
    endgenerate

    // Request decode, stall injection, compare and status read mux
    always_comb begin
        w_wb_req   = i_wb_cyc && i_wb_stb;
        w_stall    = w_wb_req && (stall_p_q[w_wb_ch] != 4'd0)
                     && (stall_cnt_q[w_wb_ch] == stall_p_q[w_wb_ch]);
        w_accept   = w_wb_req && !w_stall;
        w_live     = w_accept && (i_wb_sel != '0);
        w_st_req   = i_st_cyc && i_st_stb;
        w_seed_wr  = w_st_req && i_st_we && (i_st_addr[1:0] == 2'd0) && (i_st_sel != 4'd0);
        w_ctl_wr   = w_st_req && i_st_we && (i_st_addr[1:0] == 2'd2) && i_st_sel[0];
        w_new_seed = seed_q[w_st_ch];
        for (int b = 0; b < 4; b++) begin
            if (i_st_sel[b]) begin
                w_new_seed[8*b +: 8] = i_st_data[8*b +: 8];
            end
        end
        // Seed occupies the top 32 bits of the LFSR, low bits zero
        w_seed_init = DW'(w_new_seed) << (DW - 32);
        w_bmask = '0;
        for (int b = 0; b < SW; b++) begin
            w_bmask[8*b +: 8] = {8{i_wb_sel[b]}};
        end
        w_mismatch = |((i_wb_data ^ wr_lfsr_q[w_wb_ch]) & w_bmask);
        w_nbytes   = 16'($countones(i_wb_sel));
        case (i_st_addr[1:0])
            2'd0:    w_st_rdata = seed_q[w_st_ch];
            2'd1:    w_st_rdata = {wr_bytes_q[w_st_ch], rd_bytes_q[w_st_ch]};
            2'd2:    w_st_rdata = {err_cnt_q[w_st_ch], 8'h00, stall_p_q[w_st_ch],
                                   3'b000, err_flag_q[w_st_ch]};
            default: w_st_rdata = 32'(first_addr_q[w_st_ch]);
        endcase
    end

    // Bus acknowledge and read-data registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wb_ack_q  <= 1'b0;
            wb_data_q <= '0;
            st_ack_q  <= 1'b0;
            st_data_q <= '0;
        end else begin
            wb_ack_q <= w_accept;
            // Read data is the pre-advance value, even when a seed load collides
            if (w_live && !i_wb_we) begin
                wb_data_q <= rd_lfsr_q[w_wb_ch];
            end
            st_ack_q <= w_st_req;
            if (w_st_req) begin
                st_data_q <= w_st_rdata;
            end
        end
    end

    // Per-channel state; a seed load overrides any same-cycle beat on that channel
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < NCHAN; c++) begin
                seed_q[c]       <= '0;
                rd_lfsr_q[c]    <= '0;
                wr_lfsr_q[c]    <= '0;
                rd_bytes_q[c]   <= '0;
                wr_bytes_q[c]   <= '0;
                err_cnt_q[c]    <= '0;
                err_flag_q[c]   <= 1'b0;
                first_addr_q[c] <= '0;
                stall_p_q[c]    <= '0;
                stall_cnt_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (w_seed_wr && (w_st_ch == CIW'(c))) begin
                    seed_q[c]       <= w_new_seed;
                    rd_lfsr_q[c]    <= w_seed_init;
                    wr_lfsr_q[c]    <= w_seed_init;
                    rd_bytes_q[c]   <= '0;
                    wr_bytes_q[c]   <= '0;
                    err_cnt_q[c]    <= '0;
                    err_flag_q[c]   <= 1'b0;
                    first_addr_q[c] <= '0;
                    stall_cnt_q[c]  <= '0;
                end else begin
                    if (w_ctl_wr && (w_st_ch == CIW'(c))) begin
                        stall_p_q[c]   <= i_st_data[7:4];
                        stall_cnt_q[c] <= '0;
                    end else if (w_wb_ch == CIW'(c)) begin
                        if (w_stall) begin
                            stall_cnt_q[c] <= '0;
                        end else if (w_accept && (stall_p_q[c] != 4'd0)) begin
                            stall_cnt_q[c] <= stall_cnt_q[c] + 4'd1;
                        end
                    end
                    if (w_live && (w_wb_ch == CIW'(c))) begin
                        if (!i_wb_we) begin
                            rd_lfsr_q[c]  <= lfsr_step(rd_lfsr_q[c]);
                            rd_bytes_q[c] <= rd_bytes_q[c] + w_nbytes;
                        end else begin
                            wr_lfsr_q[c]  <= lfsr_step(wr_lfsr_q[c]);
                            wr_bytes_q[c] <= wr_bytes_q[c] + w_nbytes;
                            if (w_mismatch) begin
                                err_flag_q[c] <= 1'b1;
                                if (err_cnt_q[c] != 16'hFFFF) begin
                                    err_cnt_q[c] <= err_cnt_q[c] + 16'd1;
                                end
                                if (!err_flag_q[c]) begin
                                    first_addr_q[c] <= i_wb_addr;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    assign o_wb_stall = w_stall;
    assign o_wb_ack   = wb_ack_q;
    assign o_wb_data  = wb_data_q;
    assign o_wb_err   = 1'b0;
    assign o_st_stall = 1'b0;
    assign o_st_ack   = st_ack_q;
    assign o_st_data  = st_data_q;
    assign o_st_err   = 1'b0;

endmodule
`default_nettype wire
